// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory-side controller: default widths,
// RAM window base and the access FSM state encoding.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W = 13;
  localparam int unsigned CPU_DATA_W = 8;
  localparam logic [CPU_ADDR_W-1:0] CPU_RAM_BASE = 13'h1000;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    WR_WAIT
  } state_t;

endpackage

// File: rtl/cpu_mem_ctl_if.sv
// CPU-side bus of the memory controller: level strobes, address and write
// data from the core; read data, valid pulse, busy and error flags back.
interface cpu_mem_ctl_if #(
  parameter int ADDR_W = cpu_pkg::CPU_ADDR_W,
  parameter int DATA_W = cpu_pkg::CPU_DATA_W
);

  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdata_vld;
  logic              busy;
  logic              wr_err;

  modport master (
    output rd, wr, addr, wdata,
    input  rdata, rdata_vld, busy, wr_err
  );

  modport slave (
    input  rd, wr, addr, wdata,
    output rdata, rdata_vld, busy, wr_err
  );

endinterface

// File: rtl/cpu_mem_ram.sv
// Single-port synchronous data RAM: write enable, registered read that holds
// its output between reads, no reset.
module cpu_mem_ram #(
  parameter int AW    = 12,
  parameter int DW    = 8,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch; clearing a memory is not possible in
  // one cycle and would prevent it mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (we) mem[addr] <= wdata;
    if (re) q <= mem[addr];
  end

endmodule

// File: rtl/cpu_mem_ctl.sv
// Memory controller downstream of the 8-bit CPU: edge-detected requests,
// ROM/RAM decode, programmable wait states. Define CPU_MEM_CTL_ROM_WP_EN to
// reject writes to the ROM region.
module cpu_mem_ctl
  import cpu_pkg::*;
#(
  parameter int unsigned           ADDR_W   = CPU_ADDR_W,
  parameter int unsigned           DATA_W   = CPU_DATA_W,
  parameter logic [ADDR_W-1:0]     RAM_BASE = CPU_RAM_BASE,
  parameter int unsigned           WAIT_RD  = 1,
  parameter int unsigned           WAIT_WR  = 0
) (
  input  logic              clk,
  input  logic              rst,
  cpu_mem_ctl_if.slave      bus,
  output logic              rom_en,
  output logic [ADDR_W-2:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int RAM_DEPTH = (1 << ADDR_W) - int'(RAM_BASE);
  localparam int RAM_AW    = $clog2(RAM_DEPTH);
  localparam logic [2:0] WAIT_RD_C = 3'(WAIT_RD);
  localparam logic [2:0] WAIT_WR_C = 3'(WAIT_WR);

  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic rd_q, wr_q, rd_rise, wr_rise;
  logic acc_rd, acc_wr, err, ram_we, ram_re, rd_fin;
  logic live_ram, cap_ram, rom_pend;
  logic [ADDR_W-1:0] live_off;
  logic [RAM_AW-1:0] cap_idx, ram_addr;
  logic [DATA_W-1:0] cap_wdata, rom_q, ram_q, rdata;
  logic rdata_vld;
  logic unused_off;

  assign rd_rise    = bus.rd & ~rd_q;
  assign wr_rise    = bus.wr & ~wr_q;
  assign live_ram   = (bus.addr >= RAM_BASE);
  assign live_off   = bus.addr - RAM_BASE;
  assign unused_off = ^live_off[ADDR_W-1:RAM_AW];
  assign rd_fin     = (state == RD_WAIT) && (cnt == 3'd0);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    state_nx = state;
    cnt_nx   = cnt;
    acc_rd   = 1'b0;
    acc_wr   = 1'b0;
    err      = 1'b0;
    ram_we   = 1'b0;
    case (state)
      IDLE: begin
        if (rd_rise && wr_rise) begin
          err = 1'b1;
        end else if (rd_rise) begin
          acc_rd   = 1'b1;
          state_nx = RD_WAIT;
          cnt_nx   = WAIT_RD_C;
        end else if (wr_rise) begin
`ifdef CPU_MEM_CTL_ROM_WP_EN
          if (!live_ram) begin
            err = 1'b1;
          end else begin
            acc_wr   = 1'b1;
            state_nx = WR_WAIT;
            cnt_nx   = WAIT_WR_C;
          end
`else
          acc_wr   = 1'b1;
          state_nx = WR_WAIT;
          cnt_nx   = WAIT_WR_C;
`endif
        end
      end
      RD_WAIT: begin
        if (cnt == 3'd0) state_nx = RD_DONE;
        else             cnt_nx   = cnt - 3'd1;
      end
      RD_DONE: state_nx = IDLE;
      WR_WAIT: begin
        if (cnt == 3'd0) begin
          state_nx = IDLE;
          ram_we   = cap_ram;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state != IDLE) err = rd_rise | wr_rise;
    // Reset is synchronous: suppress anything that would act at this edge.
    if (rst) begin
      acc_rd = 1'b0;
      acc_wr = 1'b0;
      err    = 1'b0;
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rdata     <= '0;
      rdata_vld <= 1'b0;
      rom_pend  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rd_q      <= bus.rd;
      wr_q      <= bus.wr;
      rdata_vld <= rd_fin;
      if (rd_fin) rdata <= cap_ram ? ram_q : (rom_pend ? rom_data : rom_q);
      if (acc_rd)                 rom_pend <= ~live_ram;
      else if (state == RD_WAIT)  rom_pend <= 1'b0;
    end
  end

  // ROM data is only valid the cycle after rom_en, so it is parked here.
  always_ff @(posedge clk) begin
    if (acc_rd || acc_wr) begin
      cap_ram   <= live_ram;
      cap_idx   <= live_off[RAM_AW-1:0];
      cap_wdata <= bus.wdata;
    end
    if (rom_pend && state == RD_WAIT) rom_q <= rom_data;
  end

  assign ram_re   = acc_rd & live_ram;
  assign ram_addr = ram_we ? cap_idx : live_off[RAM_AW-1:0];

  cpu_mem_ram #(
    .AW    (RAM_AW),
    .DW    (DATA_W),
    .DEPTH (RAM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (cap_wdata),
    .q     (ram_q)
  );

  assign rom_en        = acc_rd & ~live_ram;
  assign rom_addr      = rom_en ? bus.addr[ADDR_W-2:0] : '0;
  assign bus.rdata     = rdata;
  assign bus.rdata_vld = rdata_vld;
  assign bus.busy      = (state != IDLE);
  assign bus.wr_err    = err;

endmodule

// File: tb/tb_cpu_mem_ctl.sv
// Bench for cpu_mem_ctl: timing-level reference model checked every cycle,
// directed literal checks, then randomized strobes/addresses/resets.
`timescale 1ns/1ps
module tb_cpu_mem_ctl;
  import cpu_pkg::*;

  localparam int WAIT_RD = 1;
  localparam int WAIT_WR = 0;
  localparam logic [12:0] BASE = CPU_RAM_BASE;
`ifdef CPU_MEM_CTL_ROM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  typedef struct {
    int          vld_n;
    int          vld_k;
    logic [7:0]  vld_data;
    int          err_n;
    int          busy_n;
    int          rom_n;
    logic [11:0] rom_a;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data = 8'h00;

  cpu_mem_ctl_if bus_if ();

  cpu_mem_ctl #(
    .RAM_BASE (BASE),
    .WAIT_RD  (WAIT_RD),
    .WAIT_WR  (WAIT_WR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] rom_fn(input logic [11:0] a);
    return a[7:0] ^ 8'h2C;
  endfunction

  // External ROM: data valid only in the cycle after rom_en, garbage otherwise.
  initial begin : rom_dev
    logic        req;
    logic [11:0] ra;
    forever begin
      @(negedge clk);
      req = rom_en;
      ra  = rom_addr;
      @(posedge clk);
      #1;
      rom_data = req ? rom_fn(ra) : 8'($urandom);
    end
  end

  // Reference model: each accepted access is described by the absolute cycles
  // at which busy starts/ends, data appears and the write lands.
  logic [7:0] ram_m [4096];
  bit         ram_k [4096];

  initial begin : model
    longint      t = 0, idle_at = 0, busy_from = 0, vld_at = -1, commit_at = -1;
    logic [7:0]  cur_rd = 8'h00, pend_rd = 8'h00, commit_d = 8'h00;
    bit          cur_k = 1'b1, pend_k = 1'b0, m_rd_q = 1'b0, m_wr_q = 1'b0, live = 1'b0;
    logic [11:0] commit_i = 12'h000, e_ra;
    logic [12:0] off;
    bit          e_vld, e_busy, e_err, e_rom, idle, rr, wrr;
    forever begin
      @(negedge clk);
      e_vld = (t == vld_at);
      if (e_vld) begin
        cur_rd = pend_rd;
        cur_k  = pend_k;
      end
      e_busy = (t >= busy_from) && (t < idle_at);
      idle   = (t >= idle_at);
      rr     = bus_if.rd && !m_rd_q;
      wrr    = bus_if.wr && !m_wr_q;
      e_err  = 1'b0;
      e_rom  = 1'b0;
      e_ra   = 12'h000;
      off    = bus_if.addr - BASE;
      if (!rst) begin
        if (!idle) begin
          e_err = rr || wrr;
        end else if (rr && wrr) begin
          e_err = 1'b1;
        end else if (rr) begin
          busy_from = t + 1;
          vld_at    = t + 2 + WAIT_RD;
          idle_at   = t + 3 + WAIT_RD;
          if (bus_if.addr >= BASE) begin
            pend_rd = ram_m[off[11:0]];
            pend_k  = ram_k[off[11:0]];
          end else begin
            e_rom   = 1'b1;
            e_ra    = bus_if.addr[11:0];
            pend_rd = rom_fn(bus_if.addr[11:0]);
            pend_k  = 1'b1;
          end
        end else if (wrr) begin
          if (bus_if.addr < BASE && WP) begin
            e_err = 1'b1;
          end else begin
            busy_from = t + 1;
            idle_at   = t + 2 + WAIT_WR;
            if (bus_if.addr >= BASE) begin
              commit_at = t + 1 + WAIT_WR;
              commit_i  = off[11:0];
              commit_d  = bus_if.wdata;
            end
          end
        end
      end
      if (live) begin
        check("busy",      bus_if.busy,      e_busy);
        check("rdata_vld", bus_if.rdata_vld, e_vld);
        check("wr_err",    bus_if.wr_err,    e_err);
        check("rom_en",    rom_en,           e_rom);
        check("rom_addr",  rom_addr,         e_ra);
        if (cur_k) check("rdata", bus_if.rdata, cur_rd);
      end
      if (rst) begin
        idle_at   = 0;
        busy_from = 0;
        vld_at    = -1;
        commit_at = -1;
        cur_rd    = 8'h00;
        cur_k     = 1'b1;
        m_rd_q    = 1'b0;
        m_wr_q    = 1'b0;
        live      = 1'b1;
      end else begin
        if (t == commit_at) begin
          ram_m[commit_i] = commit_d;
          ram_k[commit_i] = 1'b1;
        end
        m_rd_q = bus_if.rd;
        m_wr_q = bus_if.wr;
      end
      t++;
    end
  end

  // Called at posedge+1. pat[k] is the strobe level during cycle k of the run.
  task automatic access(input bit r, input bit w, input logic [12:0] a, input logic [7:0] d,
                        input logic [15:0] pat, input int span, output obs_t o);
    o.vld_n = 0; o.vld_k = -1; o.vld_data = 8'h00;
    o.err_n = 0; o.busy_n = 0; o.rom_n = 0; o.rom_a = 12'h000;
    bus_if.rd    = r & pat[0];
    bus_if.wr    = w & pat[0];
    bus_if.addr  = a;
    bus_if.wdata = d;
    for (int k = 0; k < span; k++) begin
      @(negedge clk);
      if (bus_if.rdata_vld) begin
        if (o.vld_n == 0) begin
          o.vld_k    = k;
          o.vld_data = bus_if.rdata;
        end
        o.vld_n++;
      end
      if (bus_if.wr_err) o.err_n++;
      if (bus_if.busy)   o.busy_n++;
      if (rom_en) begin
        o.rom_n++;
        o.rom_a = rom_addr;
      end
      @(posedge clk);
      #1;
      bus_if.rd   = r & pat[k+1];
      bus_if.wr   = w & pat[k+1];
      bus_if.addr = 13'($urandom);
    end
  endtask

  initial begin : stim
    obs_t o;
    bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    access(1'b0, 1'b1, 13'h1004, 8'hA5, 16'h0001, 4, o);
    check("wr_busy_len", o.busy_n, WAIT_WR + 1);
    check("wr_no_err",   o.err_n,  0);

    access(1'b1, 1'b0, 13'h1004, 8'h00, 16'h0001, 6, o);
    check("rd_vld_lat",  o.vld_k,    3);
    check("rd_data",     o.vld_data, 8'hA5);
    check("rd_busy_len", o.busy_n,   WAIT_RD + 2);

    access(1'b1, 1'b0, 13'h0010, 8'h00, 16'h0001, 6, o);
    check("rom_en_cnt",  o.rom_n,    1);
    check("rom_addr",    o.rom_a,    12'h010);
    check("rom_data",    o.vld_data, 8'h3C);

    access(1'b1, 1'b0, 13'h1004, 8'h00, 16'h03FF, 13, o);
    check("held_one_vld", o.vld_n, 1);
    check("held_no_err",  o.err_n, 0);

    access(1'b1, 1'b0, 13'h1004, 8'h00, 16'h0005, 7, o);
    check("reedge_err", o.err_n, 1);
    check("reedge_vld", o.vld_n, 1);

    access(1'b1, 1'b1, 13'h1004, 8'h00, 16'h0001, 4, o);
    check("both_err",  o.err_n,  1);
    check("both_busy", o.busy_n, 0);
    check("both_vld",  o.vld_n,  0);

    access(1'b0, 1'b1, 13'h0020, 8'h77, 16'h0001, 4, o);
    check("romwr_err",  o.err_n,  WP ? 1 : 0);
    check("romwr_busy", o.busy_n, WP ? 0 : WAIT_WR + 1);

    access(1'b0, 1'b1, 13'h1FFF, 8'hC3, 16'h0001, 4, o);
    access(1'b1, 1'b0, 13'h1FFF, 8'h00, 16'h0001, 6, o);
    check("top_ram", o.vld_data, 8'hC3);
    access(1'b1, 1'b0, 13'h0FFF, 8'h00, 16'h0001, 6, o);
    check("below_base_rom", o.rom_a,    12'hFFF);
    check("below_base_dat", o.vld_data, 8'hD3);

    // Reset while the write of 8'h11 sits in WR_WAIT.
    access(1'b0, 1'b1, 13'h1000, 8'h5A, 16'h0001, 4, o);
    bus_if.wr = 1'b1; bus_if.addr = 13'h1000; bus_if.wdata = 8'h11;
    @(posedge clk); #1;
    bus_if.wr = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  bus_if.busy,      1'b0);
    check("rst_vld",   bus_if.rdata_vld, 1'b0);
    check("rst_rdata", bus_if.rdata,     8'h00);
    check("rst_err",   bus_if.wr_err,    1'b0);
    check("rst_rom",   rom_en,           1'b0);
    @(posedge clk); #1;
    access(1'b1, 1'b0, 13'h1000, 8'h00, 16'h0001, 6, o);
    check("rst_discard", o.vld_data, 8'h5A);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 5))
        0:       bus_if.addr = 13'h0FFF;
        1:       bus_if.addr = 13'h1000;
        2:       bus_if.addr = 13'h1FFF;
        3:       bus_if.addr = 13'h1000 + 13'($urandom_range(0, 7));
        4:       bus_if.addr = 13'($urandom_range(0, 31));
        default: bus_if.addr = 13'($urandom);
      endcase
      bus_if.rd    = ($urandom_range(0, 2) == 0);
      bus_if.wr    = ($urandom_range(0, 3) == 0);
      bus_if.wdata = 8'($urandom);
      rst          = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; bus_if.rd = 1'b0; bus_if.wr = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_mem_ctl.md
# cpu_mem_ctl

Memory-side controller directly downstream of the 8-bit RISC CPU core. It consumes the core's `rd`/`wr` strobes, 13-bit `addr` and 8-bit write data, and returns read data with a valid pulse and a `busy` flag. It decodes the address into an external instruction ROM window and an internal data RAM, and inserts programmable wait states per access.

## Interface
- `ADDR_W`, 13, CPU address width
- `DATA_W`, 8, data width
- `RAM_BASE`, 13'h1000, first RAM address; addresses below it go to ROM
- `WAIT_RD`, 1, extra wait cycles per read (0–7)
- `WAIT_WR`, 0, extra wait cycles per write (0–7)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `rd`  in  1  CPU read strobe (level)
- `wr`  in  1  CPU write strobe (level)
- `addr`  in  ADDR_W  CPU address
- `wdata`  in  DATA_W  CPU write data
- `rdata`  out  DATA_W  read data, held until the next read completes
- `rdata_vld`  out  1  one-cycle pulse when `rdata` updates
- `busy`  out  1  access in progress
- `wr_err`  out  1  one-cycle pulse on an illegal request
- `rom_en`  out  1  ROM read enable
- `rom_addr`  out  ADDR_W-1  ROM address
- `rom_data`  in  DATA_W  ROM data, valid the cycle after `rom_en`

## Operation
- Requests are edge-detected against registered `rd_q`/`wr_q`:
  - a new access starts only on a 0→1 edge of `rd` or `wr` while in IDLE;
  - a held strobe never re-issues;
  - `addr` changes under a held strobe are ignored.
- On acceptance, `addr` and `wdata` are captured. The region is RAM if `addr >= RAM_BASE`, otherwise ROM.
- RAM: internal array of `2**ADDR_W - RAM_BASE` bytes, indexed by `addr - RAM_BASE`. Contents are not reset.
- `rd` and `wr` rising in the same cycle: no access, `wr_err` pulses, state stays IDLE.
- A strobe edge while not IDLE: ignored, and `wr_err` pulses.
- FSM states:
  - IDLE: accept a request.
    - Read: go to RD_WAIT. If ROM, drive `rom_en=1` and `rom_addr` for that one cycle.
    - Write: go to WR_WAIT.
  - RD_WAIT: count `WAIT_RD` cycles (0 means a single pass), then go to RD_DONE.
  - RD_DONE: latch `rdata` from the RAM or the captured `rom_data`, pulse `rdata_vld`, go to IDLE.
  - WR_WAIT: count `WAIT_WR` cycles. The RAM write commits at the edge leaving WR_WAIT; then go to IDLE.
- Wait counter is 3 bits and loads the parameter on entry to RD_WAIT/WR_WAIT.
- `busy = (state != IDLE)`.

## Timing
- Reset values: state IDLE, `rdata`=0, `rdata_vld`=0, `busy`=0, `wr_err`=0, `rom_en`=0, `rom_addr`=0, `rd_q`=`wr_q`=0.
- Read accepted at cycle N:
  - `busy` is high from N+1 through N+2+`WAIT_RD`;
  - `rdata_vld` is high in cycle N+2+`WAIT_RD`;
  - IDLE again at N+3+`WAIT_RD`.
- Write accepted at N: RAM updated at the end of cycle N+1+`WAIT_WR`; `busy` drops at N+2+`WAIT_WR`.
- Back-to-back accesses: the earliest next acceptance is the first IDLE cycle. The CPU must drop and re-raise the strobe.
- Reset mid-access:
  - return to IDLE next cycle with no `rdata_vld`;
  - an uncommitted write is discarded;
  - `rd_q`/`wr_q` clear, so a strobe still held high after reset is treated as a new edge.
- `addr = RAM_BASE - 1` goes to ROM; `addr = RAM_BASE` goes to RAM index 0; the top address maps to the last RAM byte.

## Configuration
- `CPU_MEM_CTL_ROM_WP_EN`
  - Defined: a write to the ROM region is rejected. No state change, `wr_err` pulses in the acceptance cycle, and `busy` stays low.
  - Undefined: a ROM-region write runs the normal WR_WAIT timing with no storage effect, and `wr_err` does not pulse.

## Structure
- Shared package `cpu_pkg` holds:
  - `ADDR_W`/`DATA_W` defaults;
  - the `RAM_BASE` constant;
  - the FSM state enum (IDLE, RD_WAIT, RD_DONE, WR_WAIT).
- One sub-module, `cpu_mem_ram`: a single-port synchronous RAM with write enable, registered read and no reset.

## Test plan
- Reset, then `rd` edge at `addr`=13'h1004 after writing 8'hA5 there, with `WAIT_RD`=1 → `rdata_vld` exactly 3 cycles after acceptance, `rdata`=8'hA5.
- `rd` at `addr`=13'h0010 with `rom_data`=8'h3C → `rom_en` high for one cycle with `rom_addr`=12'h010, then `rdata`=8'h3C.
- `rd` held high for 10 cycles → exactly one `rdata_vld`; a second `rd` edge while busy → `wr_err` pulse and no second access.
- `rd` and `wr` rise together → `wr_err`=1 for one cycle, `busy` stays 0.
- `wr` of 8'h77 to 13'h0020 with `CPU_MEM_CTL_ROM_WP_EN` defined → `wr_err` pulse, `busy` stays 0; undefined → `busy` for `WAIT_WR`+1 cycles and no error.
- Assert `rst` during WR_WAIT for a write of 8'h11 to 13'h1000 → a later read of 13'h1000 returns the prior value, and all outputs are at reset values on the cycle after reset.
